// File: rtl/pe_psum_collector.sv
// Receive end of the PE output-address sequence: accumulates per-PE partial sums
// over BlockCount blocks in strict PE order, then drains one result per handshake.
module pe_psum_collector #(
  parameter int O_PEGroupSize   = 4,
  parameter int O_PEAddrWidth   = 2,
  parameter int BlockCount      = 4,
  parameter int BlockCountWidth = 2,
  parameter int DataWidth       = 16,
  parameter int AccWidth        = 20
) (
  input  logic                       clk,
  input  logic                       sclr_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [O_PEAddrWidth-1:0]   in_addr,
  input  logic [DataWidth-1:0]       in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [O_PEAddrWidth-1:0]   out_addr,
  output logic [AccWidth-1:0]        out_data,
  output logic [BlockCountWidth-1:0] block_cnt,
  output logic                       err
);

  localparam logic [O_PEAddrWidth-1:0]   LastIdx = O_PEAddrWidth'(O_PEGroupSize - 1);
  localparam logic [BlockCountWidth-1:0] LastBlk = BlockCountWidth'(BlockCount - 1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                     state_r;
  logic                       in_ready_r;
  logic                       out_valid_r;
  logic [AccWidth-1:0]        out_data_r;
  logic [BlockCountWidth-1:0] block_cnt_r;
  logic                       err_r;
  logic [O_PEAddrWidth-1:0]   exp_idx_r;
  logic [O_PEAddrWidth-1:0]   d_r;
  logic [AccWidth-1:0]        acc_r [O_PEGroupSize];

  logic                       beat_s;
  logic                       good_s;
  logic                       bad_s;
  logic                       last_beat_s;
  logic                       hs_s;
  logic [AccWidth-1:0]        ext_s;
  logic [AccWidth-1:0]        sum_s;
  logic [O_PEAddrWidth-1:0]   d_next_s;

  // Beat classification and the accumulator update value for the expected PE.
  always_comb begin
    beat_s      = in_valid & in_ready_r;
    good_s      = beat_s & (in_addr == exp_idx_r);
    bad_s       = beat_s & (in_addr != exp_idx_r);
    ext_s       = {{(AccWidth - DataWidth){in_data[DataWidth-1]}}, in_data};
    if (block_cnt_r == '0) begin
      sum_s = ext_s;
    end else begin
      sum_s = acc_r[exp_idx_r] + ext_s;
    end
    last_beat_s = good_s & (exp_idx_r == LastIdx) & (block_cnt_r == LastBlk);
    hs_s        = out_valid_r & out_ready;
    d_next_s    = d_r + O_PEAddrWidth'(1);
  end

  // Accumulator storage; block 0 overwrites, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (sclr_n && good_s) begin
      acc_r[exp_idx_r] <= sum_s;
    end
  end

  // Control FSM with registered handshake outputs, counters and sticky error.
  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      state_r     <= ACCUM;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      block_cnt_r <= '0;
      err_r       <= 1'b0;
      exp_idx_r   <= '0;
      d_r         <= '0;
    end else begin
      if (bad_s) begin
        err_r <= 1'b1;
      end
      case (state_r)
        ACCUM: begin
          if (last_beat_s) begin
            state_r     <= DRAIN;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b1;
            exp_idx_r   <= '0;
            block_cnt_r <= '0;
            d_r         <= '0;
            // Slot 0 is only still being written here when the group has one PE.
            out_data_r  <= (exp_idx_r == '0) ? sum_s : acc_r[0];
          end else if (good_s && (exp_idx_r == LastIdx)) begin
            exp_idx_r   <= '0;
            block_cnt_r <= block_cnt_r + BlockCountWidth'(1);
          end else if (good_s) begin
            exp_idx_r   <= exp_idx_r + O_PEAddrWidth'(1);
          end
        end
        DRAIN: begin
          if (hs_s && (d_r == LastIdx)) begin
            state_r     <= ACCUM;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            d_r         <= '0;
            out_data_r  <= '0;
          end else if (hs_s) begin
            d_r         <= d_next_s;
            out_data_r  <= acc_r[d_next_s];
          end
        end
        default: begin
          state_r     <= ACCUM;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          d_r         <= '0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_addr  = d_r;
  assign out_data  = out_data_r;
  assign block_cnt = block_cnt_r;
  assign err       = err_r;

endmodule

// File: tb/tb_pe_psum_collector.sv
// Scoreboard bench for pe_psum_collector: stimulus pushes expected per-PE sums,
// a negedge monitor pops and compares on every output handshake.
module tb_pe_psum_collector;

  logic        clk = 1'b0;
  logic        sclr_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_addr = 2'd0;
  logic [15:0] in_data = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_addr;
  logic [19:0] out_data;
  logic [1:0]  block_cnt;
  logic        err;

  int vectors = 0;
  int miscompares = 0;
  bit rand_or = 1'b0;

  logic [1:0]  exp_addr_q [$];
  logic [19:0] exp_data_q [$];

  pe_psum_collector dut (
    .clk(clk), .sclr_n(sclr_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .block_cnt(block_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s", name, why);
  endtask

  task automatic wait_pos();
    @(posedge clk);
    #1;
  endtask

  // Random downstream backpressure when enabled.
  always begin
    @(posedge clk);
    #2;
    if (rand_or) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: compares every result handshake and checks stalled outputs hold.
  logic        prev_stall = 1'b0;
  logic [1:0]  prev_addr;
  logic [19:0] prev_data;
  always @(negedge clk) begin
    if (sclr_n && out_valid) begin
      chk("in_ready_low_in_drain", 32'(in_ready), 32'd0);
      if (prev_stall) begin
        chk("hold_addr", 32'(out_addr), 32'(prev_addr));
        chk("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (out_ready) begin
        if (exp_addr_q.size() == 0) begin
          fail_now("unexpected_output", $sformatf("addr %0d data 0x%0h with empty scoreboard", out_addr, out_data));
        end else begin
          chk("out_addr", 32'(out_addr), 32'(exp_addr_q.pop_front()));
          chk("out_data", 32'(out_data), 32'(exp_data_q.pop_front()));
        end
      end
    end
    prev_stall = sclr_n && out_valid && !out_ready;
    prev_addr  = out_addr;
    prev_data  = out_data;
  end

  task automatic send(input logic [1:0] a, input logic [15:0] dd);
    int n = 0;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = dd;
    while (!in_ready && n < 200) begin
      wait_pos();
      n++;
    end
    if (!in_ready) fail_now("send_timeout", "in_ready never rose");
    wait_pos();
    in_valid = 1'b0;
  endtask

  // mode 0: data = addr+1, mode 1: all -1, mode 2: random (with extremes).
  task automatic run_set(input int mode, input bit inject, input bit gaps);
    logic [15:0] dat [4][4];
    int          s [4];
    int          r;
    for (int p = 0; p < 4; p++) s[p] = 0;
    for (int b = 0; b < 4; b++) begin
      for (int p = 0; p < 4; p++) begin
        r = int'($urandom_range(0, 7));
        case (mode)
          0: dat[b][p] = 16'(p + 1);
          1: dat[b][p] = 16'hFFFF;
          default: dat[b][p] = (r == 0) ? 16'h8000 : (r == 1) ? 16'h7FFF : 16'($urandom);
        endcase
        s[p] += int'($signed(dat[b][p]));
      end
    end
    for (int p = 0; p < 4; p++) begin
      exp_addr_q.push_back(2'(p));
      exp_data_q.push_back(20'(s[p]));
    end
    for (int b = 0; b < 4; b++) begin
      for (int p = 0; p < 4; p++) begin
        if (gaps) repeat ($urandom_range(0, 2)) wait_pos();
        if (inject && $urandom_range(0, 3) == 0) begin
          send(2'((p + int'($urandom_range(1, 3))) % 4), 16'($urandom));
          chk("err_after_bad_beat", 32'(err), 32'd1);
          chk("block_cnt_after_bad_beat", 32'(block_cnt), 32'(b));
        end
        send(2'(p), dat[b][p]);
      end
      if (b < 3) chk("block_cnt_advance", 32'(block_cnt), 32'(b + 1));
    end
    chk("out_valid_latency", 32'(out_valid), 32'd1);
    chk("block_cnt_at_drain", 32'(block_cnt), 32'd0);
  endtask

  task automatic wait_drain(input bit junk);
    int n = 0;
    if (junk) begin
      in_valid = 1'b1;
      in_addr  = 2'($urandom);
      in_data  = 16'($urandom);
    end
    while (exp_addr_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    if (exp_addr_q.size() != 0) fail_now("drain_timeout", $sformatf("%0d results outstanding", exp_addr_q.size()));
    wait_pos();
    chk("accum_resume_in_ready", 32'(in_ready), 32'd1);
    chk("accum_resume_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    // Reset
    sclr_n = 1'b0;
    wait_pos();
    sclr_n = 1'b1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_block_cnt", 32'(block_cnt), 32'd0);
    chk("reset_err", 32'(err), 32'd0);

    // Basic accumulate: 4,8,12,16
    out_ready = 1'b1;
    run_set(0, 1'b0, 1'b0);
    wait_drain(1'b0);

    // Backpressure at d=1 for three cycles
    out_ready = 1'b0;
    run_set(0, 1'b0, 1'b0);
    out_ready = 1'b1;
    wait_pos();
    out_ready = 1'b0;
    chk("stall_addr", 32'(out_addr), 32'd1);
    chk("stall_data", 32'(out_data), 32'd8);
    repeat (3) wait_pos();
    out_ready = 1'b1;
    wait_drain(1'b0);

    // Sign extension and wrap: all -1
    rand_or = 1'b1;
    run_set(1, 1'b0, 1'b1);
    wait_drain(1'b1);

    // Random clean sets, input junk during drain must not flag
    for (int k = 0; k < 4; k++) begin
      run_set(2, 1'b0, 1'b1);
      wait_drain(1'b1);
    end
    chk("err_clean_sets", 32'(err), 32'd0);

    // Ordering error on the first beat
    send(2'd2, 16'd5);
    chk("err_set", 32'(err), 32'd1);
    chk("err_block_cnt", 32'(block_cnt), 32'd0);
    run_set(0, 1'b0, 1'b0);
    wait_drain(1'b0);

    // Random sets with injected ordering errors
    for (int k = 0; k < 3; k++) begin
      run_set(2, 1'b1, 1'b1);
      wait_drain(1'b1);
    end
    chk("err_sticky", 32'(err), 32'd1);

    // Reset mid-drain at d=2
    rand_or = 1'b0;
    out_ready = 1'b0;
    run_set(2, 1'b0, 1'b0);
    out_ready = 1'b1;
    wait_pos();
    wait_pos();
    out_ready = 1'b0;
    chk("mid_drain_addr", 32'(out_addr), 32'd2);
    chk("results_left_at_reset", 32'(exp_addr_q.size()), 32'd2);
    sclr_n = 1'b0;
    wait_pos();
    sclr_n = 1'b1;
    exp_addr_q.delete();
    exp_data_q.delete();
    chk("mid_reset_out_valid", 32'(out_valid), 32'd0);
    chk("mid_reset_in_ready", 32'(in_ready), 32'd1);
    chk("mid_reset_block_cnt", 32'(block_cnt), 32'd0);
    chk("mid_reset_err", 32'(err), 32'd0);
    rand_or = 1'b1;
    run_set(2, 1'b0, 1'b1);
    wait_drain(1'b0);

    rand_or = 1'b0;
    repeat (2) wait_pos();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
